// File: rtl/cpu_pkg.sv
// Shared definitions for the micro-coded CPU control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    // Instruction-register upper nibble. 1001..1101 are undefined and decode as NOP.
    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    // Encodings 0..4 equal the micro-step index, so step can be read straight off the state.
    typedef enum logic [2:0] {
        ST_T0     = 3'd0,
        ST_T1     = 3'd1,
        ST_T2     = 3'd2,
        ST_T3     = 3'd3,
        ST_T4     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    localparam int CTRL_W = 16;

    // Bit positions of each strobe inside the control word.
    localparam int B_PC_OUT   = 0;
    localparam int B_PC_INC   = 1;
    localparam int B_PC_LOAD  = 2;
    localparam int B_MAR_IN   = 3;
    localparam int B_RAM_IN   = 4;
    localparam int B_RAM_OUT  = 5;
    localparam int B_IR_IN    = 6;
    localparam int B_IR_OUT   = 7;
    localparam int B_A_IN     = 8;
    localparam int B_A_OUT    = 9;
    localparam int B_B_IN     = 10;
    localparam int B_ALU_OUT  = 11;
    localparam int B_ALU_SUB  = 12;
    localparam int B_OUT_IN   = 13;
    localparam int B_FLAGS_IN = 14;
    localparam int B_HALT     = 15;

    // One-hot mask for a strobe index.
    function automatic logic [CTRL_W-1:0] strobe(input int idx);
        logic [CTRL_W-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/microcode_decoder.sv
// Combinational decode of (state, opcode, flags, run) into the 16-bit control word.
// Latency: 0 cycles. Ports: state/opcode/carry_flag/zero_flag/run in; ctrl, last out.
// Backpressure: run=0 blanks every strobe except halt in HALTED; last flags an instruction's final step.
module microcode_decoder
    import cpu_pkg::*;
(
    input  logic [2:0]  state,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    input  logic        run,
    output logic [15:0] ctrl,
    output logic        last
);

    state_e            st;
    logic [CTRL_W-1:0] word;

    assign st = state_e'(state);

    always_comb begin
        word = '0;
        last = 1'b0;
        case (st)
            ST_T0: word = strobe(B_PC_OUT) | strobe(B_MAR_IN);
            ST_T1: word = strobe(B_RAM_OUT) | strobe(B_IR_IN) | strobe(B_PC_INC);
            ST_T2: begin
                last = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        word = strobe(B_IR_OUT) | strobe(B_MAR_IN);
                        last = 1'b0;
                    end
                    OP_LDI: word = strobe(B_IR_OUT) | strobe(B_A_IN);
                    OP_JMP: word = strobe(B_IR_OUT) | strobe(B_PC_LOAD);
                    // Untaken branch issues nothing at all, not even ir_out.
                    OP_JC:  word = carry_flag ? (strobe(B_IR_OUT) | strobe(B_PC_LOAD)) : '0;
                    OP_JZ:  word = zero_flag  ? (strobe(B_IR_OUT) | strobe(B_PC_LOAD)) : '0;
                    OP_OUT: word = strobe(B_A_OUT) | strobe(B_OUT_IN);
                    OP_HLT: word = strobe(B_HALT);
                    default: word = '0;
                endcase
            end
            ST_T3: begin
                last = 1'b1;
                case (opcode)
                    OP_LDA: word = strobe(B_RAM_OUT) | strobe(B_A_IN);
                    OP_ADD, OP_SUB: begin
                        word = strobe(B_RAM_OUT) | strobe(B_B_IN);
                        last = 1'b0;
                    end
                    OP_STA: word = strobe(B_A_OUT) | strobe(B_RAM_IN);
                    // Opcode changed under an instruction: close it out cleanly.
                    default: word = '0;
                endcase
            end
            ST_T4: begin
                last = 1'b1;
                case (opcode)
                    OP_ADD: word = strobe(B_ALU_OUT) | strobe(B_A_IN) | strobe(B_FLAGS_IN);
                    OP_SUB: word = strobe(B_ALU_OUT) | strobe(B_A_IN) | strobe(B_FLAGS_IN)
                                 | strobe(B_ALU_SUB);
                    default: word = '0;
                endcase
            end
            ST_HALTED: word = strobe(B_HALT);
            default: begin
                word = '0;
                last = 1'b1;
            end
        endcase

        // HALTED keeps its halt strobe regardless of run.
        if (st == ST_HALTED) begin
            ctrl = strobe(B_HALT);
        end else if (run) begin
            ctrl = word;
        end else begin
            ctrl = '0;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step sequencer: owns the T0..T4/HALTED state register, decode is delegated.
// Latency: ctrl is combinational from the current state; one micro-step per clock when run=1.
// Backpressure: run=0 freezes the step and forces strobes low; rst=0 clears state and ctrl at once.
// Ports: clk, rst (async active-low), run, opcode, carry_flag, zero_flag -> ctrl[15:0], step[2:0].
module control_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    output logic [15:0] ctrl,
    output logic [2:0]  step
);

    state_e      state;
    logic [15:0] dec_ctrl;
    logic        dec_last;

    microcode_decoder u_decoder (
        .state      (state),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .run        (run),
        .ctrl       (dec_ctrl),
        .last       (dec_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_T0;
        end else if (run && state != ST_HALTED) begin
            // The halt strobe only appears in T2 of HLT, so it doubles as the halt trigger.
            if (dec_ctrl[B_HALT]) begin
                state <= ST_HALTED;
            end else if (dec_last) begin
                state <= ST_T0;
            end else begin
                state <= state_e'(state + 3'd1);
            end
        end
    end

    // Reset must blank everything, halt included, even though state already reads T0.
    assign ctrl = rst ? dec_ctrl : '0;
    // HALTED is not a micro-step; report 0 so the debug index stays within 0..4.
    assign step = (state == ST_HALTED) ? 3'd0 : state;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam logic [15:0] PC_OUT   = 16'h0001;
    localparam logic [15:0] PC_INC   = 16'h0002;
    localparam logic [15:0] PC_LOAD  = 16'h0004;
    localparam logic [15:0] MAR_IN   = 16'h0008;
    localparam logic [15:0] RAM_IN   = 16'h0010;
    localparam logic [15:0] RAM_OUT  = 16'h0020;
    localparam logic [15:0] IR_IN    = 16'h0040;
    localparam logic [15:0] IR_OUT   = 16'h0080;
    localparam logic [15:0] A_IN     = 16'h0100;
    localparam logic [15:0] A_OUT    = 16'h0200;
    localparam logic [15:0] B_IN     = 16'h0400;
    localparam logic [15:0] ALU_OUT  = 16'h0800;
    localparam logic [15:0] ALU_SUB  = 16'h1000;
    localparam logic [15:0] OUT_IN   = 16'h2000;
    localparam logic [15:0] FLAGS_IN = 16'h4000;
    localparam logic [15:0] HALT     = 16'h8000;
    localparam logic [15:0] DRIVERS  = PC_OUT | RAM_OUT | IR_OUT | A_OUT | ALU_OUT;
    localparam logic [15:0] F0 = PC_OUT | MAR_IN;
    localparam logic [15:0] F1 = RAM_OUT | IR_IN | PC_INC;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  opcode;
    logic        carry_flag;
    logic        zero_flag;
    logic [15:0] ctrl;
    logic [2:0]  step;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (ctrl),
        .step       (step)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_true(input string name, input bit cond, input logic [15:0] act);
        total++;
        if (!cond) begin
            bad++;
            $display("FAIL %s: got %h want rule satisfied", name, act);
        end
    endtask

    // ---------------- reference model: microprogram per opcode ----------------
    function automatic int prog_len(input logic [3:0] op);
        case (op)
            4'b0001, 4'b0100: return 4;
            4'b0010, 4'b0011: return 5;
            default:          return 3;
        endcase
    endfunction

    function automatic logic [15:0] ucode(input logic [3:0] op, input int k, input logic c, input logic z);
        logic [15:0] prog [5];
        prog = '{F0, F1, 16'h0, 16'h0, 16'h0};
        case (op)
            4'b0001: begin prog[2] = IR_OUT | MAR_IN; prog[3] = RAM_OUT | A_IN; end
            4'b0010: begin prog[2] = IR_OUT | MAR_IN; prog[3] = RAM_OUT | B_IN;
                           prog[4] = ALU_OUT | A_IN | FLAGS_IN; end
            4'b0011: begin prog[2] = IR_OUT | MAR_IN; prog[3] = RAM_OUT | B_IN;
                           prog[4] = ALU_OUT | A_IN | FLAGS_IN | ALU_SUB; end
            4'b0100: begin prog[2] = IR_OUT | MAR_IN; prog[3] = A_OUT | RAM_IN; end
            4'b0101: prog[2] = IR_OUT | A_IN;
            4'b0110: prog[2] = IR_OUT | PC_LOAD;
            4'b0111: prog[2] = c ? (IR_OUT | PC_LOAD) : 16'h0;
            4'b1000: prog[2] = z ? (IR_OUT | PC_LOAD) : 16'h0;
            4'b1110: prog[2] = A_OUT | OUT_IN;
            4'b1111: prog[2] = HALT;
            default: prog[2] = 16'h0;
        endcase
        return (k < prog_len(op)) ? prog[k] : 16'h0;
    endfunction

    int m_step = 0;
    bit m_halted = 0;

    // One model-checked clock: drive, check at negedge, advance at posedge.
    task automatic tick(input logic r, input logic [3:0] op, input logic c, input logic z,
                        input string tag);
        logic [15:0] exp;
        run = r; opcode = op; carry_flag = c; zero_flag = z;
        @(negedge clk);
        exp = m_halted ? HALT : (r ? ucode(op, m_step, c, z) : 16'h0);
        check({tag, " ctrl"}, ctrl, exp);
        if (!m_halted) check({tag, " step"}, {13'd0, step}, 16'(m_step));
        check_true({tag, " step_range"}, step <= 3'd4, {13'd0, step});
        check_true({tag, " one_driver"}, $countones(ctrl & DRIVERS) <= 1, ctrl);
        check_true({tag, " reg_rw"},
                   !((ctrl & A_IN) != 0 && (ctrl & A_OUT) != 0) &&
                   !((ctrl & RAM_IN) != 0 && (ctrl & RAM_OUT) != 0) &&
                   !((ctrl & IR_IN) != 0 && (ctrl & IR_OUT) != 0) &&
                   !((ctrl & PC_LOAD) != 0 && (ctrl & PC_OUT) != 0), ctrl);
        @(posedge clk);
        #1;
        if (!m_halted && r) begin
            if (op == 4'b1111 && m_step == 2) m_halted = 1;
            else if (m_step >= prog_len(op) - 1) m_step = 0;
            else m_step++;
        end
    endtask

    // Pulse reset starting just after a rising edge, release just after the next one.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, " rst_ctrl"}, ctrl, 16'h0);
        check({tag, " rst_step"}, {13'd0, step}, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_step = 0;
        m_halted = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [15:0] exp_ctrl;
        logic [2:0]  exp_step;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] op, input logic c, input logic z,
                       input logic [15:0] e, input logic [2:0] s);
        vec_t v;
        v.r = r; v.op = op; v.c = c; v.z = z; v.exp_ctrl = e; v.exp_step = s;
        tbl.push_back(v);
    endtask

    int instrs;
    int cycles;
    logic [3:0] cur_op;

    initial begin
        rst = 1'b0; run = 1'b1; opcode = 4'b0010; carry_flag = 1'b1; zero_flag = 1'b1;
        #2;
        check("por ctrl", ctrl, 16'h0);
        check("por step", {13'd0, step}, 16'h0);
        @(posedge clk);
        #1;
        check("por clocked ctrl", ctrl, 16'h0);
        rst = 1'b1;

        // ADD, SUB, JC/JZ both ways, LDA with a run stall at T3, OUT, NOP, then HLT.
        add(1, 4'b0010, 0, 0, F0, 0); add(1, 4'b0010, 0, 0, F1, 1);
        add(1, 4'b0010, 0, 0, IR_OUT | MAR_IN, 2); add(1, 4'b0010, 0, 0, RAM_OUT | B_IN, 3);
        add(1, 4'b0010, 0, 0, ALU_OUT | A_IN | FLAGS_IN, 4);
        add(1, 4'b0011, 0, 0, F0, 0); add(1, 4'b0011, 0, 0, F1, 1);
        add(1, 4'b0011, 0, 0, IR_OUT | MAR_IN, 2); add(1, 4'b0011, 0, 0, RAM_OUT | B_IN, 3);
        add(1, 4'b0011, 0, 0, ALU_OUT | A_IN | FLAGS_IN | ALU_SUB, 4);
        add(1, 4'b0111, 0, 1, F0, 0); add(1, 4'b0111, 0, 1, F1, 1); add(1, 4'b0111, 0, 1, 16'h0, 2);
        add(1, 4'b0111, 1, 0, F0, 0); add(1, 4'b0111, 1, 0, F1, 1);
        add(1, 4'b0111, 1, 0, IR_OUT | PC_LOAD, 2);
        add(1, 4'b1000, 1, 0, F0, 0); add(1, 4'b1000, 1, 0, F1, 1); add(1, 4'b1000, 1, 0, 16'h0, 2);
        add(1, 4'b1000, 0, 1, F0, 0); add(1, 4'b1000, 0, 1, F1, 1);
        add(1, 4'b1000, 0, 1, IR_OUT | PC_LOAD, 2);
        add(1, 4'b0001, 0, 0, F0, 0); add(1, 4'b0001, 0, 0, F1, 1);
        add(1, 4'b0001, 0, 0, IR_OUT | MAR_IN, 2);
        add(0, 4'b0001, 0, 0, 16'h0, 3); add(0, 4'b0001, 0, 0, 16'h0, 3); add(0, 4'b0001, 0, 0, 16'h0, 3);
        add(1, 4'b0001, 0, 0, RAM_OUT | A_IN, 3);
        add(1, 4'b1110, 0, 0, F0, 0); add(1, 4'b1110, 0, 0, F1, 1); add(1, 4'b1110, 0, 0, A_OUT | OUT_IN, 2);
        add(1, 4'b1011, 1, 1, F0, 0); add(1, 4'b1011, 1, 1, F1, 1); add(1, 4'b1011, 1, 1, 16'h0, 2);
        add(1, 4'b1111, 0, 0, F0, 0); add(1, 4'b1111, 0, 0, F1, 1); add(1, 4'b1111, 0, 0, HALT, 2);

        foreach (tbl[i]) begin
            run = tbl[i].r; opcode = tbl[i].op; carry_flag = tbl[i].c; zero_flag = tbl[i].z;
            @(negedge clk);
            check($sformatf("vec%0d ctrl", i), ctrl, tbl[i].exp_ctrl);
            check($sformatf("vec%0d step", i), {13'd0, step}, {13'd0, tbl[i].exp_step});
            @(posedge clk);
            #1;
        end

        // HALTED holds halt only, whatever run and opcode do.
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom_range(0, 1)); opcode = 4'($urandom_range(0, 15));
            carry_flag = 1'($urandom_range(0, 1)); zero_flag = 1'($urandom_range(0, 1));
            @(negedge clk);
            check($sformatf("halted%0d ctrl", i), ctrl, HALT);
            @(posedge clk);
            #1;
        end

        // Async reset out of HALTED, then a fresh fetch.
        #2;
        do_reset("halt_rst");
        tick(1, 4'b0101, 0, 0, "post_halt T0");
        tick(1, 4'b0101, 0, 0, "post_halt T1");
        tick(1, 4'b0101, 0, 0, "post_halt T2");

        // Reset abandons an instruction in flight.
        tick(1, 4'b0011, 0, 0, "abandon T0");
        tick(1, 4'b0011, 0, 0, "abandon T1");
        tick(1, 4'b0011, 0, 0, "abandon T2");
        #2;
        do_reset("abandon_rst");
        tick(1, 4'b0011, 0, 0, "abandon new T0");
        tick(1, 4'b0011, 0, 0, "abandon new T1");

        // Randomized instruction stream checked against the microprogram model.
        do_reset("rand_rst");
        instrs = 0;
        cycles = 0;
        cur_op = 4'b0000;
        while (instrs < 500 && cycles < 20000) begin
            logic r;
            r = ($urandom_range(0, 3) != 0);
            if (m_halted) begin
                if ($urandom_range(0, 3) == 0) do_reset("rand_halt_rst");
            end else if (m_step == 0) begin
                cur_op = 4'($urandom_range(0, 15));
                if (r) instrs++;
            end
            tick(r, cur_op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
            cycles++;
        end
        check_true("rand budget", instrs >= 500, 16'(instrs));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, independent of clk).
REQ-003 SHALL have port: run  input  1  1 = advance one micro-step per clock; 0 = freeze step and force all strobes low.
REQ-004 SHALL have port: opcode  input  4  instruction-register upper nibble; valid from step T2 onward.
REQ-005 SHALL have port: carry_flag, zero_flag  input  1 each  latched ALU flags from the flags register.
REQ-006 SHALL have port: ctrl  output  16  control word, one strobe per bit: pc_out, pc_inc, pc_load, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in, alu_out, alu_sub, out_in, flags_in, halt.
REQ-007 SHALL have port: step  output  3  current micro-step index 0..4 (debug).

Function
REQ-008 SHALL hold a registered step counter with states T0..T4 plus a terminal HALTED state.
REQ-009 SHALL decode ctrl combinationally from (registered state, opcode, carry_flag, zero_flag, run).
REQ-010 Fetch, all opcodes: T0 -> pc_out, mar_in; T1 -> ram_out, ir_in, pc_inc.
REQ-011 LDA 0001: T2 ir_out, mar_in; T3 ram_out, a_in (last step).
REQ-012 ADD 0010: T2 ir_out, mar_in; T3 ram_out, b_in; T4 alu_out, a_in, flags_in (last step).
REQ-013 SUB 0011: same as ADD; alu_sub additionally asserted in T4.
REQ-014 STA 0100: T2 ir_out, mar_in; T3 a_out, ram_in (last step).
REQ-015 LDI 0101: T2 ir_out, a_in (last). JMP 0110: T2 ir_out, pc_load (last).
REQ-016 JC 0111 / JZ 1000: T2 ir_out, pc_load if carry_flag / zero_flag = 1, else no strobes; T2 is last step either way.
REQ-017 OUT 1110: T2 a_out, out_in (last). HLT 1111: T2 halt, then enter HALTED.
REQ-018 NOP 0000 and undefined opcodes 1001..1101: T2 with no strobes (last step).
REQ-019 After an instruction's last step, the next active clock SHALL load T0; no idle cycle between instructions.
REQ-020 Flags SHALL be sampled in the same cycle as T2 decode (no internal flag storage).
REQ-021 HALTED SHALL assert only halt, ignore run and opcode, and persist until reset.
REQ-022 run=0 SHALL freeze state (step unchanged) and drive ctrl=0 except halt in HALTED; run=1 resumes at the frozen step.
REQ-023 In every cycle at most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) SHALL be asserted.
REQ-024 No register SHALL receive its bus-read and bus-write strobe in the same cycle.

Reset
REQ-025 rst=0 SHALL set state to T0 and step to 0 immediately, independent of clk.
REQ-026 While rst=0, ctrl SHALL be all zeros, including halt.
REQ-027 Reset asserted mid-instruction or in HALTED SHALL abandon it; first active clock after release executes T0 -> T1.

Structure
REQ-028 Opcode enum, step/state enum, and the ctrl bit-index constants SHALL live in shared package cpu_pkg.
REQ-029 The (state, opcode, flags) -> ctrl decode SHALL be a separate combinational sub-module microcode_decoder; control_sequencer keeps the state register.

Verification
REQ-030 Reset, run=1: T0 ctrl = pc_out|mar_in; T1 = ram_out|ir_in|pc_inc; step reads 0, 1.
REQ-031 opcode=0010: T2 ir_out|mar_in, T3 ram_out|b_in, T4 alu_out|a_in|flags_in, next cycle step=0. opcode=0011: same, alu_sub set in T4.
REQ-032 opcode=0111: carry=0 -> T2 ctrl=0, next step=0; carry=1 -> T2 ir_out|pc_load. Repeat for 1000 with zero_flag.
REQ-033 opcode=1111 -> halt in T2, halt stays 1 for 20 cycles with run toggling and opcode changing; rst=0 pulse mid-cycle clears halt asynchronously.
REQ-034 opcode=0001, run=0 at T3 for 3 cycles -> ctrl=0, step=3 held; run=1 -> ram_out|a_in, then step=0.
REQ-035 500 random instructions with random run/flags: REQ-023 and REQ-024 checked every cycle, no step value above 4.
